// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : SPI transmitter for a 12-bit MCP4921-class DAC. Takes one
//                {cfg, sample} word per valid/ready handshake. Shifts it out
//                MSB-first on CS/SCK/SDI, then pulses LDAC. Ends each frame
//                with a one-cycle frame_done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_tx #(
   parameter int m        = 12,
   parameter int CMD_BITS = 4,
   parameter int CLK_DIV  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [m-1:0]        sample,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [CMD_BITS-1:0] cfg,
   output logic                dac_cs_n,
   output logic                dac_sck,
   output logic                dac_sdi,
   output logic                dac_ldac_n,
   output logic                frame_done
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int C_W    = CMD_BITS + m;
   localparam int C_DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int C_BITW = (C_W > 1) ? $clog2(C_W) : 1;

   localparam logic [C_DIVW-1:0] C_DIV_LAST  = C_DIVW'(CLK_DIV - 1);
   localparam logic [C_BITW-1:0] C_BIT_FIRST = C_BITW'(C_W - 1);

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_SHIFT = 2'd1;
   localparam logic [1:0] C_HOLD  = 2'd2;
   localparam logic [1:0] C_LDAC  = 2'd3;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]        r_state;
   logic              r_phase;     // 0 = SCK low half, 1 = SCK high half
   logic [C_DIVW-1:0] r_divcnt;
   logic [C_BITW-1:0] r_bitcnt;
   logic [C_W-2:0]    r_shift;     // bits still to be sent after the one on SDI

   logic              r_cs_n;
   logic              r_sck;
   logic              r_sdi;
   logic              r_ldac_n;
   logic              r_ready;
   logic              r_done;

   // ------------------------------------------------------------------------
   // Decoded events
   // ------------------------------------------------------------------------
   logic [C_W-1:0] w_frame;
   logic           w_accept;
   logic           w_div_end;
   logic           w_low_end;
   logic           w_bit_end;
   logic           w_last_bit;
   logic           w_shift_done;
   logic           w_next_bit;
   logic           w_hold_end;
   logic           w_ldac_end;

   assign w_frame      = {cfg, sample};
   // r_ready is high exactly in IDLE, so no combinational path from valid
   assign w_accept     = r_ready && sample_valid;
   assign w_div_end    = (r_divcnt == C_DIV_LAST);
   assign w_low_end    = (r_state == C_SHIFT) && !r_phase && w_div_end;
   assign w_bit_end    = (r_state == C_SHIFT) &&  r_phase && w_div_end;
   assign w_last_bit   = (r_bitcnt == '0);
   assign w_shift_done = w_bit_end && w_last_bit;
   assign w_next_bit   = w_bit_end && !w_last_bit;
   assign w_hold_end   = (r_state == C_HOLD) && w_div_end;
   assign w_ldac_end   = (r_state == C_LDAC) && w_div_end;

   // ------------------------------------------------------------------------
   // Half-period divider: free-runs in every non-idle state, wraps at
   // CLK_DIV-1. All state and phase changes happen on its wrap.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divcnt <= '0;
      end else if ((r_state == C_IDLE) || w_div_end) begin
         r_divcnt <= '0;
      end else begin
         r_divcnt <= r_divcnt + C_DIVW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Frame sequencer: state, SCK phase and the down-counting bit index.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= C_IDLE;
         r_phase  <= 1'b0;
         r_bitcnt <= '0;
      end else begin
         case (r_state)
            C_IDLE: begin
               if (w_accept) begin
                  r_state  <= C_SHIFT;
                  r_phase  <= 1'b0;
                  r_bitcnt <= C_BIT_FIRST;
               end
            end
            C_SHIFT: begin
               if (w_low_end) begin
                  r_phase <= 1'b1;
               end else if (w_next_bit) begin
                  r_phase  <= 1'b0;
                  r_bitcnt <= r_bitcnt - C_BITW'(1);
               end else if (w_shift_done) begin
                  r_phase <= 1'b0;
                  r_state <= C_HOLD;
               end
            end
            C_HOLD: begin
               if (w_hold_end) begin
                  r_state <= C_LDAC;
               end
            end
            C_LDAC: begin
               if (w_ldac_end) begin
                  r_state <= C_IDLE;
               end
            end
            default: begin
               r_state  <= C_IDLE;
               r_phase  <= 1'b0;
               r_bitcnt <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Data path: capture the frame at accept and present one bit per SCK
   // period. SDI changes only when a new low half begins.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_sdi   <= 1'b0;
      end else if (w_accept) begin
         r_shift <= w_frame[C_W-2:0];
         r_sdi   <= w_frame[C_W-1];
      end else if (w_next_bit) begin
         r_shift <= {r_shift[C_W-3:0], 1'b0};
         r_sdi   <= r_shift[C_W-2];
      end else if (w_shift_done) begin
         r_shift <= '0;
         r_sdi   <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Pin drivers: each output is its own flop so CS and SCK cannot glitch.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_n   <= 1'b1;
         r_sck    <= 1'b0;
         r_ldac_n <= 1'b1;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_ldac_end;

         if (w_accept) begin
            r_cs_n <= 1'b0;
         end else if (w_hold_end) begin
            r_cs_n <= 1'b1;
         end

         if (w_low_end) begin
            r_sck <= 1'b1;
         end else if (w_bit_end) begin
            r_sck <= 1'b0;
         end

         if (w_hold_end) begin
            r_ldac_n <= 1'b0;
         end else if (w_ldac_end) begin
            r_ldac_n <= 1'b1;
         end

         if (w_accept) begin
            r_ready <= 1'b0;
         end else if (w_ldac_end) begin
            r_ready <= 1'b1;
         end
      end
   end

   assign sample_ready = r_ready;
   assign dac_cs_n     = r_cs_n;
   assign dac_sck      = r_sck;
   assign dac_sdi      = r_sdi;
   assign dac_ldac_n   = r_ldac_n;
   assign frame_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_tx
//  Description : Self-checking bench for dac_spi_tx. Uses a default DUT with
//                CLK_DIV=2 and a second DUT with CLK_DIV=1. Expected frames
//                are queued as stimulus is driven. A negedge monitor rebuilds
//                the frames the DAC would latch and measures the strobe widths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT 0 (defaults, CLK_DIV=2) ----------------
   logic        rst_n;
   logic [11:0] sample;
   logic [3:0]  cfg;
   logic        valid;
   logic        ready, cs_n, sck, sdi, ldac_n, done;

   dac_spi_tx #(.m(12), .CMD_BITS(4), .CLK_DIV(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(valid),
      .sample_ready(ready), .cfg(cfg), .dac_cs_n(cs_n), .dac_sck(sck),
      .dac_sdi(sdi), .dac_ldac_n(ldac_n), .frame_done(done));

   // ---------------- DUT 1 (CLK_DIV=1) ----------------
   logic        rst1_n;
   logic [11:0] sample1;
   logic [3:0]  cfg1;
   logic        valid1;
   logic        ready1, cs1_n, sck1, sdi1, ldac1_n, done1;

   dac_spi_tx #(.m(12), .CMD_BITS(4), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .sample(sample1), .sample_valid(valid1),
      .sample_ready(ready1), .cfg(cfg1), .dac_cs_n(cs1_n), .dac_sck(sck1),
      .dac_sdi(sdi1), .dac_ldac_n(ldac1_n), .frame_done(done1));

   int n_cmp = 0;
   int n_bad = 0;

   // scoreboard queues
   logic [15:0] exp_q[$];
   logic [15:0] rx_q[$];
   int          rxn_q[$];
   int          gap_q[$];
   logic [15:0] exp1_q[$];
   logic [15:0] rx1_q[$];
   int          rxn1_q[$];

   // ---------------- monitor for DUT 0 ----------------
   logic        p_sck = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_ready = 1'b1;
   logic [15:0] sh = '0;
   int          nb = 0;
   int          cs_cnt = 0, cs_low_len = 0, hi_cnt = 0;
   int          ld_cnt = 0, ld_len = 0, ldac_pulses = 0;
   int          rd_cnt = 0, rd_len = 0, done_cnt = 0;
   logic        ld_at_cs = 1'b0, done_w_ready = 1'b0;

   always @(negedge clk) begin
      p_sck   <= sck;
      p_cs    <= cs_n;
      p_ldac  <= ldac_n;
      p_ready <= ready;
      if (cs_n === 1'b0 && sck === 1'b1 && p_sck === 1'b0) begin
         sh <= {sh[14:0], sdi};
         nb <= nb + 1;
      end
      if (cs_n === 1'b0) cs_cnt <= cs_cnt + 1;
      if (cs_n === 1'b1) hi_cnt <= hi_cnt + 1;
      if (cs_n === 1'b1 && p_cs === 1'b0) begin
         cs_low_len <= cs_cnt;
         cs_cnt     <= 0;
         sh         <= '0;
         nb         <= 0;
         if (rst_n === 1'b1) begin
            rx_q.push_back(sh);
            rxn_q.push_back(nb);
         end
      end
      if (cs_n === 1'b0 && p_cs === 1'b1) begin
         gap_q.push_back(hi_cnt);
         hi_cnt <= 0;
      end
      if (ldac_n === 1'b0) ld_cnt <= ld_cnt + 1;
      if (ldac_n === 1'b1 && p_ldac === 1'b0) begin
         ld_len <= ld_cnt;
         ld_cnt <= 0;
      end
      if (ldac_n === 1'b0 && p_ldac === 1'b1) begin
         ldac_pulses <= ldac_pulses + 1;
         ld_at_cs    <= (cs_n === 1'b1 && p_cs === 1'b0);
      end
      if (ready === 1'b0) rd_cnt <= rd_cnt + 1;
      if (ready === 1'b1 && p_ready === 1'b0) begin
         rd_len       <= rd_cnt;
         rd_cnt       <= 0;
         done_w_ready <= done;
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // ---------------- monitor for DUT 1 ----------------
   logic        p_sck1 = 1'b0, p_cs1 = 1'b1, p_ready1 = 1'b1;
   logic [15:0] sh1 = '0;
   int          nb1 = 0, cs1_cnt = 0, cs1_len = 0, rd1_cnt = 0, rd1_len = 0;
   int          per_cnt = 0, pmin = 99, pmax = 0;

   always @(negedge clk) begin
      p_sck1   <= sck1;
      p_cs1    <= cs1_n;
      p_ready1 <= ready1;
      if (cs1_n === 1'b0 && sck1 === 1'b1 && p_sck1 === 1'b0) begin
         sh1     <= {sh1[14:0], sdi1};
         nb1     <= nb1 + 1;
         per_cnt <= 1;
         if (nb1 != 0) begin
            if (per_cnt < pmin) pmin <= per_cnt;
            if (per_cnt > pmax) pmax <= per_cnt;
         end
      end else begin
         per_cnt <= per_cnt + 1;
      end
      if (cs1_n === 1'b0) cs1_cnt <= cs1_cnt + 1;
      if (cs1_n === 1'b1 && p_cs1 === 1'b0) begin
         cs1_len <= cs1_cnt;
         cs1_cnt <= 0;
         sh1     <= '0;
         nb1     <= 0;
         if (rst1_n === 1'b1) begin
            rx1_q.push_back(sh1);
            rxn1_q.push_back(nb1);
         end
      end
      if (cs1_n === 1'b0 && p_cs1 === 1'b1) begin
         pmin <= 99;
         pmax <= 0;
      end
      if (ready1 === 1'b0) rd1_cnt <= rd1_cnt + 1;
      if (ready1 === 1'b1 && p_ready1 === 1'b0) begin
         rd1_len <= rd1_cnt;
         rd1_cnt <= 0;
      end
   end

   // ---------------- drivers (no checking inside) ----------------
   // Present a word on DUT 0 and hold valid until it has been accepted.
   task automatic drive0(input logic [11:0] s, input logic [3:0] c, output bit ok);
      int t = 0;
      @(negedge clk);
      sample = s; cfg = c; valid = 1'b1;
      while (ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      ok = (t < 300);
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_rx0(input int need, output bit ok);
      int t = 0;
      while (rx_q.size() < need && t < 400) begin @(posedge clk); #1; t++; end
      ok = (rx_q.size() >= need);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({cs_n, sck, sdi, ldac_n, ready, done, cs1_n, sck1, sdi1, ldac1_n, ready1, done1}
             !== 12'b100110_100110) begin
            n_bad++;
            $display("FAIL reset_idle cycle %0d: got %b required 100110_100110", i,
                     {cs_n, sck, sdi, ldac_n, ready, done, 1'b0, cs1_n, sck1, sdi1, ldac1_n, ready1, done1});
         end
      end
   endtask

   task automatic test_single();
      bit ok; int d0; int t; logic [15:0] e, g; int gn;
      d0 = done_cnt;
      exp_q.push_back(16'h7A5C);
      drive0(12'hA5C, 4'b0111, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_accept: got timeout required accept"); end
      wait_rx0(1, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL single_rx: got no frame required 7a5c");
      end else begin
         e = exp_q.pop_front(); g = rx_q.pop_front(); gn = rxn_q.pop_front();
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL single_data: got %h required %h", g, e); end
         n_cmp++; if (gn !== 16) begin n_bad++; $display("FAIL single_edges: got %0d required 16", gn); end
      end
      t = 0;
      while (done_cnt == d0 && t < 50) begin @(posedge clk); #1; t++; end
      repeat (10) @(posedge clk); #1;
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt - d0); end
      n_cmp++; if (cs_low_len !== 66) begin n_bad++; $display("FAIL single_cs_low: got %0d required 66", cs_low_len); end
      n_cmp++; if (ld_len !== 2) begin n_bad++; $display("FAIL single_ldac_low: got %0d required 2", ld_len); end
      n_cmp++; if (ld_at_cs !== 1'b1) begin n_bad++; $display("FAIL single_ldac_at_cs_rise: got %b required 1", ld_at_cs); end
      n_cmp++; if (rd_len !== 68) begin n_bad++; $display("FAIL single_ready_low: got %0d required 68", rd_len); end
      n_cmp++; if (done_w_ready !== 1'b1) begin n_bad++; $display("FAIL single_done_with_ready: got %b required 1", done_w_ready); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] vals[3];
      bit ok; int d0; int t; logic [15:0] e, g; int gn;
      vals[0] = 12'h000; vals[1] = 12'hFFF; vals[2] = 12'h800;
      d0 = done_cnt;
      gap_q.delete();
      for (int k = 0; k < 3; k++) exp_q.push_back({4'b0111, vals[k]});
      @(negedge clk);
      sample = vals[0]; cfg = 4'b0111; valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         t = 0;
         while (ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
         n_cmp++; if (t >= 300) begin n_bad++; $display("FAIL b2b_accept%0d: got timeout required accept", k); end
         @(posedge clk); #1;
         if (k < 2) sample = vals[k+1]; else valid = 1'b0;
         @(negedge clk);
      end
      wait_rx0(3, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_rx: got %0d frames required 3", rx_q.size()); end
      for (int k = 0; k < 3; k++) begin
         if (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); gn = rxn_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_data%0d: got %h required %h", k, g, e); end
            n_cmp++; if (gn !== 16) begin n_bad++; $display("FAIL b2b_edges%0d: got %0d required 16", k, gn); end
         end
      end
      exp_q.delete();
      t = 0;
      while ((done_cnt - d0) < 3 && t < 100) begin @(posedge clk); #1; t++; end
      repeat (10) @(posedge clk); #1;
      n_cmp++; if (done_cnt - d0 !== 3) begin n_bad++; $display("FAIL b2b_done_pulses: got %0d required 3", done_cnt - d0); end
      n_cmp++;
      if (gap_q.size() < 3) begin
         n_bad++; $display("FAIL b2b_gaps: got %0d cs falls required 3", gap_q.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            n_cmp++; if (gap_q[k] !== 3) begin n_bad++; $display("FAIL b2b_cs_gap%0d: got %0d required 3", k, gap_q[k]); end
         end
      end
   endtask

   task automatic test_capture();
      bit ok; logic [15:0] e, g;
      exp_q.push_back(16'h7A5C);
      drive0(12'hA5C, 4'b0111, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL capture_accept: got timeout required accept"); end
      sample = 12'h123; cfg = 4'b0011;
      wait_rx0(1, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL capture_rx: got no frame required 7a5c");
      end else begin
         e = exp_q.pop_front(); g = rx_q.pop_front(); void'(rxn_q.pop_front());
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL capture_data: got %h required %h", g, e); end
      end
      repeat (10) @(posedge clk);
   endtask

   task automatic test_reset_midframe();
      bit ok; int t; int d0, l0; logic [15:0] e, g; int gn;
      drive0(12'hA5C, 4'b0111, ok);   // frame will be cut off: nothing queued
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_accept: got timeout required accept"); end
      t = 0;
      while (nb < 5 && t < 400) begin @(posedge clk); #1; t++; end
      n_cmp++; if (nb < 5) begin n_bad++; $display("FAIL rst_wait_edges: got %0d required 5", nb); end
      d0 = done_cnt; l0 = ldac_pulses;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cs_n, sck, sdi, ldac_n, ready, done} !== 6'b100110) begin
         n_bad++; $display("FAIL rst_async_outputs: got %b required 100110", {cs_n, sck, sdi, ldac_n, ready, done});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk); #1;
      n_cmp++; if (rx_q.size() !== 0) begin n_bad++; $display("FAIL rst_no_frame: got %0d frames required 0", rx_q.size()); end
      n_cmp++; if (ldac_pulses !== l0) begin n_bad++; $display("FAIL rst_no_ldac: got %0d required %0d", ldac_pulses, l0); end
      n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL rst_no_done: got %0d required %0d", done_cnt, d0); end
      rx_q.delete(); rxn_q.delete();
      exp_q.push_back(16'h73C3);
      drive0(12'h3C3, 4'b0111, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_next_accept: got timeout required accept"); end
      wait_rx0(1, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL rst_next_rx: got no frame required 73c3");
      end else begin
         e = exp_q.pop_front(); g = rx_q.pop_front(); gn = rxn_q.pop_front();
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rst_next_data: got %h required %h", g, e); end
         n_cmp++; if (gn !== 16) begin n_bad++; $display("FAIL rst_next_edges: got %0d required 16", gn); end
      end
      repeat (10) @(posedge clk);
   endtask

   task automatic test_div1();
      int t; logic [15:0] e, g; int gn;
      exp1_q.push_back(16'hF555);
      @(negedge clk);
      sample1 = 12'h555; cfg1 = 4'b1111; valid1 = 1'b1;
      t = 0;
      while (ready1 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      n_cmp++; if (t >= 300) begin n_bad++; $display("FAIL div1_accept: got timeout required accept"); end
      @(posedge clk); #1;
      valid1 = 1'b0;
      t = 0;
      while (rx1_q.size() == 0 && t < 200) begin @(posedge clk); #1; t++; end
      n_cmp++;
      if (rx1_q.size() == 0) begin
         n_bad++; $display("FAIL div1_rx: got no frame required f555");
      end else begin
         e = exp1_q.pop_front(); g = rx1_q.pop_front(); gn = rxn1_q.pop_front();
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL div1_data: got %h required %h", g, e); end
         n_cmp++; if (gn !== 16) begin n_bad++; $display("FAIL div1_edges: got %0d required 16", gn); end
      end
      repeat (10) @(posedge clk); #1;
      n_cmp++; if (cs1_len !== 33) begin n_bad++; $display("FAIL div1_cs_low: got %0d required 33", cs1_len); end
      n_cmp++; if (rd1_len !== 34) begin n_bad++; $display("FAIL div1_ready_low: got %0d required 34", rd1_len); end
      n_cmp++;
      if (pmin !== 2 || pmax !== 2) begin
         n_bad++; $display("FAIL div1_sck_period: got min %0d max %0d required 2", pmin, pmax);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n = 1'b0; rst1_n = 1'b0;
      valid = 1'b0; sample = '0; cfg = '0;
      valid1 = 1'b0; sample1 = '0; cfg1 = '0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1; rst1_n = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_capture();
      test_reset_midframe();
      test_div1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case a scenario never returns.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
